// File: rtl/int_to_float32.sv
// rtl/int_to_float32.sv - iterative 32-bit integer to IEEE-754 float32 encoder, start/done handshake.
// Define ITOF_RNE_EN for round-to-nearest-even; otherwise the fraction is truncated.
module int_to_float32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] src,
    input  logic        is_signed,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_sign;
    logic [31:0] r_mag;
    logic [7:0]  r_exp;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_result;
    logic [3:0]  r_flags;

    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_sign;
    logic [31:0] w_mag;
    logic        w_mag_zero;
    logic [22:0] w_frac;
    logic        w_guard;
    logic        w_sticky;
    logic        w_round_up;
    logic        w_carry;
    logic [22:0] w_frac_rnd;
    logic [7:0]  w_exp_rnd;

    // Two's complement negate keeps 0x80000000 as its own magnitude.
    assign w_sign     = is_signed & src[31];
    assign w_mag      = w_sign ? (~src + 32'd1) : src;
    assign w_mag_zero = (w_mag == 32'd0);

    assign w_frac   = r_mag[30:8];
    assign w_guard  = r_mag[7];
    assign w_sticky = |r_mag[6:0];

`ifdef ITOF_RNE_EN
    assign w_round_up = w_guard & (w_sticky | w_frac[0]);
`else
    assign w_round_up = 1'b0;
`endif

    // An all-ones fraction wraps to zero and bumps the exponent; max exponent is 159.
    assign {w_carry, w_frac_rnd} = {1'b0, w_frac} + {23'd0, w_round_up};
    assign w_exp_rnd             = r_exp + {7'd0, w_carry};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_mag_zero ? S_DONE : S_NORM;
                end
            end
            S_NORM: begin
                if (r_mag[31]) begin
                    w_state_nxt = S_ROUND;
                end
            end
            S_ROUND: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs are computed from the next state so they can be registered.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            S_IDLE:  w_busy_nxt = 1'b0;
            S_NORM:  w_busy_nxt = 1'b1;
            S_ROUND: w_busy_nxt = 1'b1;
            S_DONE: begin
                w_busy_nxt = 1'b1;
                w_done_nxt = 1'b1;
            end
            default: w_busy_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sign   <= 1'b0;
            r_mag    <= 32'd0;
            r_exp    <= 8'd0;
            r_result <= 32'd0;
            r_flags  <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sign <= w_sign;
                        r_mag  <= w_mag;
                        r_exp  <= 8'd158;
                        if (w_mag_zero) begin
                            r_result <= 32'd0;
                            r_flags  <= 4'b0100;
                        end
                    end
                end
                S_NORM: begin
                    if (!r_mag[31]) begin
                        r_mag <= {r_mag[30:0], 1'b0};
                        r_exp <= r_exp - 8'd1;
                    end
                end
                S_ROUND: begin
                    r_result <= {r_sign, w_exp_rnd, w_frac_rnd};
                    r_flags  <= {r_sign, 1'b0, w_carry, w_guard | w_sticky};
                end
                default: begin
                    r_mag <= r_mag;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign flags  = r_flags;

endmodule

// File: tb/tb_int_to_float32.sv
// tb/tb_int_to_float32.sv - vector table plus scoreboard bench for int_to_float32 (RNE or truncate build).
module tb_int_to_float32;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] src;
    logic        is_signed;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_fail   = 0;

    int_to_float32 dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src       (src),
        .is_signed (is_signed),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] src;
        logic        sgn;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] last_res;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Reference: locate the leading one, then shift and round by explicit remainder bits.
    task automatic model(input logic [31:0] s, input logic sg,
                         output logic [31:0] res, output logic [3:0] fl, output int lat);
        logic        neg;
        logic [31:0] m;
        logic [31:0] mant;
        logic [31:0] rem;
        logic [22:0] frac;
        logic [24:0] t;
        logic        g;
        logic        st;
        logic        c;
        int          p;
        int          sh;
        int          e;
        neg = sg & s[31];
        m   = neg ? (32'd0 - s) : s;
        g   = 1'b0;
        st  = 1'b0;
        c   = 1'b0;
        if (m == 32'd0) begin
            res = 32'd0;
            fl  = 4'b0100;
            lat = 1;
        end else begin
            p = 0;
            for (int i = 0; i < 32; i++) if (m[i]) p = i;
            lat = 3 + (31 - p);
            e   = 127 + p;
            if (p <= 23) begin
                mant = m << (23 - p);
                frac = mant[22:0];
            end else begin
                sh   = p - 23;
                mant = m >> sh;
                frac = mant[22:0];
                rem  = m & ((32'd1 << sh) - 32'd1);
                g    = rem[sh-1];
                st   = (rem & ((32'd1 << (sh - 1)) - 32'd1)) != 32'd0;
            end
`ifdef ITOF_RNE_EN
            if (g && (st || frac[0])) begin
                t = {2'b01, frac} + 25'd1;
                if (t[24]) begin
                    e    = e + 1;
                    frac = 23'd0;
                    c    = 1'b1;
                end else begin
                    frac = t[22:0];
                end
            end
`endif
            res = {neg, e[7:0], frac};
            fl  = {neg, 1'b0, c, g | st};
        end
    endtask

    // Drive one conversion, wait for done, compare against the scoreboard head.
    task automatic conv(input logic [31:0] s, input logic sg, input logic [31:0] er,
                        input logic [3:0] ef, input int el, input string nm);
        exp_t x;
        int   cyc;
        bit   held;
        x.res = er;
        x.flg = ef;
        x.lat = el;
        @(negedge clk);
        start     = 1'b1;
        src       = s;
        is_signed = sg;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        start     = 1'b0;
        src       = $urandom;
        is_signed = 1'($urandom);
        cyc  = 0;
        held = 1'b1;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (result !== last_res) held = 1'b0;
        end
        chk({nm, " done_seen"}, {31'd0, done}, 32'd1);
        chk({nm, " result_held"}, {31'd0, held}, 32'd1);
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            chk({nm, " result"}, result, x.res);
            chk({nm, " flags"}, {28'd0, flags}, {28'd0, x.flg});
            chk({nm, " latency"}, cyc, x.lat);
        end
        last_res = result;
        @(negedge clk);
        chk({nm, " done_pulse"}, {30'd0, done, busy}, 32'd0);
    endtask

    vec_t vecs[$];
    int   seen;
    logic [3:0] pat;

    initial begin
        vec_t v;
        logic [31:0] r;
        logic [3:0]  f;
        int          l;

        reset = 1'b0; start = 1'b0; src = 32'd0; is_signed = 1'b0;
        last_res = 32'd0;

`ifdef ITOF_RNE_EN
        vecs.push_back('{32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 4'b0011, 3});
        vecs.push_back('{32'h0100_0003, 1'b0, 32'h4B80_0002, 4'b0001, 10});
        vecs.push_back('{32'h7FFF_FFFF, 1'b1, 32'h4F00_0000, 4'b0011, 4});
`else
        vecs.push_back('{32'hFFFF_FFFF, 1'b0, 32'h4F7F_FFFF, 4'b0001, 3});
        vecs.push_back('{32'h0100_0003, 1'b0, 32'h4B80_0001, 4'b0001, 10});
        vecs.push_back('{32'h7FFF_FFFF, 1'b1, 32'h4EFF_FFFF, 4'b0001, 4});
`endif
        vecs.push_back('{32'h0000_0001, 1'b1, 32'h3F80_0000, 4'b0000, 34});
        vecs.push_back('{32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 4'b1000, 34});
        vecs.push_back('{32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0100, 1});
        vecs.push_back('{32'h8000_0000, 1'b1, 32'hCF00_0000, 4'b1000, 3});
        vecs.push_back('{32'h8000_0000, 1'b0, 32'h4F00_0000, 4'b0000, 3});
        vecs.push_back('{32'h0100_0001, 1'b0, 32'h4B80_0000, 4'b0001, 10});
        vecs.push_back('{32'hFFFF_FFFB, 1'b1, 32'hC0A0_0000, 4'b1000, 32});

        repeat (3) @(negedge clk);
        chk("reset result", result, 32'd0);
        chk("reset flags_busy_done", {26'd0, flags, busy, done}, 32'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            v = vecs[i];
            conv(v.src, v.sgn, v.res, v.flg, v.lat, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 12; i++) begin
            v.src = $urandom >> $urandom_range(0, 31);
            v.sgn = 1'($urandom);
            model(v.src, v.sgn, r, f, l);
            conv(v.src, v.sgn, r, f, l, $sformatf("rnd%0d", i));
        end

        // start pulsed mid-flight is dropped and never queued
        model(32'd1, 1'b1, r, f, l);
        fork
            conv(32'd1, 1'b1, r, f, l, "ignore_start");
            begin
                repeat (6) @(negedge clk);
                start = 1'b1;
                src   = 32'd7;
                @(negedge clk);
                start = 1'b0;
            end
        join
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("ignore_start no_requeue", seen, 0);

        // reset in cycle 5 of a long conversion aborts it
        @(negedge clk);
        start = 1'b1; src = 32'd1; is_signed = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort result", result, 32'd0);
        chk("abort flags_busy_done", {26'd0, flags, busy, done}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        last_res = 32'd0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort no_done", seen, 0);
        model(32'h0000_1234, 1'b0, r, f, l);
        conv(32'h0000_1234, 1'b0, r, f, l, "after_reset");

        // start held high on zero input: accepted again only from IDLE
        @(negedge clk);
        start = 1'b1; src = 32'd0; is_signed = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat[3-i] = done;
            if (i == 3) start = 1'b0;
        end
        chk("back_to_back done_pattern", {28'd0, pat}, 32'b1010);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
